// File: rtl/prf_write_arbiter_pkg.sv
// prf_write_arbiter_pkg: shared writeback result type and register-index widths
package prf_write_arbiter_pkg;
  localparam int PREG_W    = 6;
  localparam int ROB_IDX_W = 5;
  typedef struct packed {
    logic [PREG_W-1:0]    preg;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } wb_result_t;
endpackage

// File: rtl/prf_write_arbiter_wb_hold_reg.sv
// prf_write_arbiter_wb_hold_reg: one-entry per-unit holding register, candidate mux and ready
module prf_write_arbiter_wb_hold_reg
  import prf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       valid_i,
  input  wb_result_t res_i,
  input  logic       grant_i,
  output logic       ready_o,
  output logic       cand_valid_o,
  output wb_result_t cand_o
);
  logic       hold_valid_q, hold_valid_d;
  wb_result_t hold_q, hold_d;
  assign ready_o      = !hold_valid_q;
  assign cand_valid_o = hold_valid_q || valid_i;
  assign cand_o       = hold_valid_q ? hold_q : res_i;
  // capture an accepted-but-ungranted input; release a held entry once granted
  always_comb begin
    hold_valid_d = flush_i ? 1'b0 : hold_valid_q ? !grant_i : valid_i && !grant_i;
    hold_d       = (!hold_valid_q && valid_i && !grant_i) ? res_i : hold_q;
  end
  // holding register state
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end
endmodule

// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter: grants exec results to shared PRF write ports / CDB slots; WB_RR_ARB_EN selects round-robin over fixed priority
module prf_write_arbiter
  import prf_write_arbiter_pkg::*;
#(
  parameter int NUM_EXEC_UNITS = 3,
  parameter int NUM_WB_PORTS   = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush_i,
  input  logic [NUM_EXEC_UNITS-1:0]                     exec_valid_i,
  input  logic [NUM_EXEC_UNITS-1:0][PREG_W-1:0]         exec_preg_i,
  input  logic [NUM_EXEC_UNITS-1:0][31:0]               exec_data_i,
  input  logic [NUM_EXEC_UNITS-1:0][ROB_IDX_W-1:0]      exec_rob_idx_i,
  output logic [NUM_EXEC_UNITS-1:0]                     exec_ready_o,
  output logic [NUM_WB_PORTS-1:0]                       prf_wr_en_o,
  output logic [NUM_WB_PORTS-1:0][PREG_W-1:0]           prf_wr_preg_o,
  output logic [NUM_WB_PORTS-1:0][31:0]                 prf_wr_data_o,
  output logic [NUM_WB_PORTS-1:0]                       cdb_valid_o,
  output logic [NUM_WB_PORTS-1:0][PREG_W-1:0]           cdb_preg_o,
  output logic [NUM_WB_PORTS-1:0][ROB_IDX_W-1:0]        cdb_rob_idx_o
);
  localparam int IDX_W = NUM_EXEC_UNITS > 1 ? $clog2(NUM_EXEC_UNITS) : 1;
  logic [NUM_EXEC_UNITS-1:0] cand_valid, grant;
  wb_result_t                in_res [NUM_EXEC_UNITS];
  wb_result_t                cand   [NUM_EXEC_UNITS];
  logic [NUM_WB_PORTS-1:0]   port_vld;
  logic [IDX_W-1:0]          port_sel [NUM_WB_PORTS];
  logic [IDX_W-1:0]          start_ptr, idx;
  int                        n;
  logic [NUM_WB_PORTS-1:0]   wr_en_q, cdb_valid_q;
  wb_result_t                out_q [NUM_WB_PORTS];
  for (genvar u = 0; u < NUM_EXEC_UNITS; u++) begin : g_unit
    assign in_res[u] = '{preg: exec_preg_i[u], data: exec_data_i[u], rob_idx: exec_rob_idx_i[u]};
    prf_write_arbiter_wb_hold_reg u_hold (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .valid_i      (exec_valid_i[u]),
      .res_i        (in_res[u]),
      .grant_i      (grant[u]),
      .ready_o      (exec_ready_o[u]),
      .cand_valid_o (cand_valid[u]),
      .cand_o       (cand[u])
    );
  end
`ifdef WB_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, last_idx;
  // next scan starts just past the highest-numbered port's unit, i.e. the last one granted
  always_comb begin
    last_idx = '0;
    for (int k = 0; k < NUM_WB_PORTS; k++) last_idx = port_vld[k] ? port_sel[k] : last_idx;
    rr_ptr_d = |grant ? (last_idx == IDX_W'(NUM_EXEC_UNITS - 1) ? '0 : last_idx + 1'b1) : rr_ptr_q;
  end
  // round-robin pointer, restarted by reset and flush
  always_ff @(posedge clk) begin
    if (rst || flush_i) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif
  // scan units from start_ptr, handing out ports 0,1,... to the first candidates found
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_sel = '{default: '0};
    n        = 0;
    idx      = '0;
    for (int i = 0; i < NUM_EXEC_UNITS; i++) begin
      idx = IDX_W'((int'(start_ptr) + i) % NUM_EXEC_UNITS);
      if (cand_valid[idx] && n < NUM_WB_PORTS) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
          if (k == n) begin
            port_vld[k] = 1'b1;
            port_sel[k] = idx;
          end
        end
        n = n + 1;
      end
    end
  end
  // registered write/broadcast ports; idle ports keep their last payload
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= '0;
      cdb_valid_q <= '0;
      out_q       <= '{default: '0};
    end else begin
      for (int k = 0; k < NUM_WB_PORTS; k++) begin
        cdb_valid_q[k] <= !flush_i && port_vld[k];
        wr_en_q[k]     <= !flush_i && port_vld[k] && cand[port_sel[k]].preg != '0;
        if (!flush_i && port_vld[k]) out_q[k] <= cand[port_sel[k]];
      end
    end
  end
  for (genvar k = 0; k < NUM_WB_PORTS; k++) begin : g_port
    assign prf_wr_preg_o[k] = out_q[k].preg;
    assign prf_wr_data_o[k] = out_q[k].data;
    assign cdb_preg_o[k]    = out_q[k].preg;
    assign cdb_rob_idx_o[k] = out_q[k].rob_idx;
  end
  assign prf_wr_en_o = wr_en_q;
  assign cdb_valid_o = cdb_valid_q;
endmodule

// File: tb/tb_prf_write_arbiter.sv
// tb_prf_write_arbiter: directed checks of the writeback port arbiter
module tb_prf_write_arbiter;
  logic            clk = 1'b0;
  logic            rst, flush;
  logic [2:0]      ev;
  logic [2:0][5:0] ep;
  logic [2:0][31:0] ed;
  logic [2:0][4:0] er;
  logic [2:0]      rdy;
  logic [1:0]      wen, cv;
  logic [1:0][5:0] wpreg, cpreg;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0] crob;
  int vec = 0;
  int miss = 0;

  prf_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .exec_valid_i   (ev),
    .exec_preg_i    (ep),
    .exec_data_i    (ed),
    .exec_rob_idx_i (er),
    .exec_ready_o   (rdy),
    .prf_wr_en_o    (wen),
    .prf_wr_preg_o  (wpreg),
    .prf_wr_data_o  (wdata),
    .cdb_valid_o    (cv),
    .cdb_preg_o     (cpreg),
    .cdb_rob_idx_o  (crob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ev = '0; ep = '0; ed = '0; er = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic present3(input logic [5:0] p0, p1, p2);
    ev = 3'b111;
    ep[0] = p0; ep[1] = p1; ep[2] = p2;
    ed[0] = 32'h100 + 32'(p0); ed[1] = 32'h100 + 32'(p1); ed[2] = 32'h100 + 32'(p2);
    er[0] = 5'(p0); er[1] = 5'(p1); er[2] = 5'(p2);
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (rdy !== 3'b111) begin miss++; $display("FAIL reset_ready got %b want 111", rdy); end
    vec++; if (wen !== 2'b00 || cv !== 2'b00) begin miss++; $display("FAIL reset_valids got wen=%b cv=%b want 00/00", wen, cv); end
    vec++; if (wpreg !== '0 || wdata !== '0 || crob !== '0 || cpreg !== '0) begin miss++; $display("FAIL reset_payload got preg=%h data=%h rob=%h want 0", wpreg, wdata, crob); end
  endtask

  task automatic test_single();
    do_reset();
    ev = 3'b010; ep[1] = 6'd12; ed[1] = 32'hDEADBEEF; er[1] = 5'd3;
    tick();
    ev = '0;
    vec++; if (wen !== 2'b01 || cv !== 2'b01) begin miss++; $display("FAIL single_en got wen=%b cv=%b want 01/01", wen, cv); end
    vec++; if (wpreg[0] !== 6'd12 || cpreg[0] !== 6'd12 || wdata[0] !== 32'hDEADBEEF || crob[0] !== 5'd3) begin miss++; $display("FAIL single_payload got preg=%0d data=%h rob=%0d want 12 deadbeef 3", wpreg[0], wdata[0], crob[0]); end
    vec++; if (rdy !== 3'b111) begin miss++; $display("FAIL single_ready got %b want 111", rdy); end
    tick();
    vec++; if (wen !== 2'b00 || cv !== 2'b00 || wpreg[0] !== 6'd12) begin miss++; $display("FAIL single_idle got wen=%b cv=%b preg=%0d want 00 00 12", wen, cv, wpreg[0]); end
  endtask

  task automatic test_contention();
    do_reset();
    present3(6'd5, 6'd6, 6'd7);
    tick();
    vec++; if (cv !== 2'b11 || wpreg[0] !== 6'd5 || wpreg[1] !== 6'd6) begin miss++; $display("FAIL cont_c1 got cv=%b p0=%0d p1=%0d want 11 5 6", cv, wpreg[0], wpreg[1]); end
    vec++; if (rdy !== 3'b011) begin miss++; $display("FAIL cont_c1_ready got %b want 011", rdy); end
    ev = 3'b011;
    ep[0] = 6'd8; ed[0] = 32'h108; er[0] = 5'd8;
    ep[1] = 6'd9; ed[1] = 32'h109; er[1] = 5'd9;
    tick();
    ev = '0;
`ifdef WB_RR_ARB_EN
    vec++; if (cv !== 2'b11 || wpreg[0] !== 6'd7 || wpreg[1] !== 6'd8) begin miss++; $display("FAIL cont_c2 got cv=%b p0=%0d p1=%0d want 11 7 8", cv, wpreg[0], wpreg[1]); end
    vec++; if (rdy !== 3'b101) begin miss++; $display("FAIL cont_c2_ready got %b want 101", rdy); end
    tick();
    vec++; if (cv !== 2'b01 || wpreg[0] !== 6'd9 || wdata[0] !== 32'h109 || crob[0] !== 5'd9) begin miss++; $display("FAIL cont_c3 got cv=%b p0=%0d d0=%h want 01 9 109", cv, wpreg[0], wdata[0]); end
`else
    vec++; if (cv !== 2'b11 || wpreg[0] !== 6'd8 || wpreg[1] !== 6'd9) begin miss++; $display("FAIL cont_c2 got cv=%b p0=%0d p1=%0d want 11 8 9", cv, wpreg[0], wpreg[1]); end
    vec++; if (rdy !== 3'b011) begin miss++; $display("FAIL cont_c2_ready got %b want 011", rdy); end
    tick();
    vec++; if (cv !== 2'b01 || wpreg[0] !== 6'd7 || wdata[0] !== 32'h107 || crob[0] !== 5'd7) begin miss++; $display("FAIL cont_c3 got cv=%b p0=%0d d0=%h want 01 7 107", cv, wpreg[0], wdata[0]); end
`endif
    vec++; if (rdy !== 3'b111) begin miss++; $display("FAIL cont_c3_ready got %b want 111", rdy); end
    tick();
    vec++; if (cv !== 2'b00 || wen !== 2'b00) begin miss++; $display("FAIL cont_drain got cv=%b wen=%b want 00 00", cv, wen); end
  endtask

  task automatic test_x0();
    do_reset();
    ev = 3'b001; ep[0] = 6'd0; ed[0] = 32'h55; er[0] = 5'd4;
    tick();
    ev = '0;
    vec++; if (cv !== 2'b01 || crob[0] !== 5'd4) begin miss++; $display("FAIL x0_cdb got cv=%b rob=%0d want 01 4", cv, crob[0]); end
    vec++; if (wen !== 2'b00) begin miss++; $display("FAIL x0_wen got %b want 00", wen); end
  endtask

  task automatic test_flush();
    do_reset();
    present3(6'd5, 6'd6, 6'd7);
    tick();
    vec++; if (rdy !== 3'b011) begin miss++; $display("FAIL flush_pre_ready got %b want 011", rdy); end
    flush = 1'b1;
    ev = 3'b001; ep[0] = 6'd20; ed[0] = 32'hAA; er[0] = 5'd20;
    tick();
    flush = 1'b0; ev = '0;
    vec++; if (cv !== 2'b00 || wen !== 2'b00 || rdy !== 3'b111) begin miss++; $display("FAIL flush_c1 got cv=%b wen=%b rdy=%b want 00 00 111", cv, wen, rdy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vec++; if (cv !== 2'b00 || wen !== 2'b00) begin miss++; $display("FAIL flush_after%0d got cv=%b wen=%b want 00 00", i, cv, wen); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    present3(6'd5, 6'd6, 6'd7);
    tick();
    ev = 3'b011;
    tick();
    rst = 1'b1; ev = '0;
    tick();
    rst = 1'b0;
    vec++; if (cv !== 2'b00 || wen !== 2'b00 || rdy !== 3'b111) begin miss++; $display("FAIL rstmid_valid got cv=%b wen=%b rdy=%b want 00 00 111", cv, wen, rdy); end
    vec++; if (wpreg !== '0 || wdata !== '0 || crob !== '0) begin miss++; $display("FAIL rstmid_payload got preg=%h data=%h rob=%h want 0", wpreg, wdata, crob); end
    tick();
    vec++; if (cv !== 2'b00) begin miss++; $display("FAIL rstmid_after got cv=%b want 00", cv); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp0 [6];
    logic [5:0] exp1 [6];
`ifdef WB_RR_ARB_EN
    exp0 = '{6'd1, 6'd3, 6'd2, 6'd1, 6'd3, 6'd2};
    exp1 = '{6'd2, 6'd1, 6'd3, 6'd2, 6'd1, 6'd3};
`else
    exp0 = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
    exp1 = '{6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2};
`endif
    do_reset();
    present3(6'd1, 6'd2, 6'd3);
    for (int c = 0; c < 6; c++) begin
      tick();
      vec++; if (cv !== 2'b11 || wpreg[0] !== exp0[c] || wpreg[1] !== exp1[c]) begin miss++; $display("FAIL b2b_c%0d got cv=%b p0=%0d p1=%0d want 11 %0d %0d", c, cv, wpreg[0], wpreg[1], exp0[c], exp1[c]); end
    end
    ev = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/prf_write_arbiter.md
Name: prf_write_arbiter

Overview:
- Writeback-side counterpart of the PRF exec read-port arbitration.
- NUM_EXEC_UNITS exec units produce results that compete for NUM_WB_PORTS shared PRF write ports.
- Each granted result drives one PRF write port and one CDB broadcast slot for ROB/reservation-station wakeup.
- Ungranted results are held in a per-unit one-entry holding register, and that unit is back-pressured with ready.

Parameters:
- NUM_EXEC_UNITS, 3, number of result producers; index 0 has highest fixed priority.
- NUM_WB_PORTS, 2, number of PRF write ports / CDB slots; must be ≤ NUM_EXEC_UNITS.
- PREG_W, 6, physical register index width.
- ROB_IDX_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (branch mispredict); drops all buffered and in-flight results
- exec_valid[NUM_EXEC_UNITS]  in  1  result valid
- exec_preg[NUM_EXEC_UNITS]  in  PREG_W  destination preg
- exec_data[NUM_EXEC_UNITS]  in  32  result value
- exec_rob_idx[NUM_EXEC_UNITS]  in  ROB_IDX_W  ROB entry
- exec_ready[NUM_EXEC_UNITS]  out  1  unit may present a new result
- prf_wr_en[NUM_WB_PORTS]  out  1  PRF write enable
- prf_wr_preg[NUM_WB_PORTS]  out  PREG_W  PRF write index
- prf_wr_data[NUM_WB_PORTS]  out  32  PRF write data
- cdb_valid[NUM_WB_PORTS]  out  1  broadcast valid
- cdb_preg[NUM_WB_PORTS]  out  PREG_W  broadcast tag
- cdb_rob_idx[NUM_WB_PORTS]  out  ROB_IDX_W  ROB completion index

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - All hold_valid = 0, so exec_ready = 1.
  - All prf_wr_en, cdb_valid = 0.
  - preg, data and rob outputs = 0.
  - rr_ptr = 0.
- Handshake:
  - A result transfers when exec_valid && exec_ready in the same cycle.
  - exec_ready[u] = !hold_valid[u], a pure register output with no combinational path from exec_valid.
- Candidate per unit:
  - If hold_valid[u], the holding register is the candidate.
  - Otherwise, if exec_valid[u], the live input is the candidate.
  - A held result always has precedence over new input; new input is blocked anyway because ready = 0.
- Arbitration:
  - Scan units from the priority start; the first NUM_WB_PORTS candidates are granted.
  - Grants are assigned to ports 0,1,… in scan order.
  - Priority start is unit 0 (fixed priority) unless WB_RR_ARB_EN is defined.
- Latency:
  - Outputs are registered, so a granted candidate appears on port k one cycle after grant.
  - An input granted in its arrival cycle therefore has 1-cycle latency.
- Holding register:
  - A live input that is accepted but not granted is captured into hold[u] (hold_valid = 1).
  - A held candidate that is granted clears hold_valid next cycle.
  - A held candidate that is not granted stays held.
- x0 results (preg == 0):
  - Still take a port, with cdb_valid = 1 so the ROB completes.
  - prf_wr_en = 0 for that port.
- Unused ports: the enable/valid is 0 next cycle; data and tag are don't-care (hold previous value).
- Flush:
  - Next cycle all hold_valid = 0 and all output valids = 0.
  - Inputs presented in the flush cycle are discarded, but still count as accepted (ready was 1).
- Reset mid-operation: same effect as flush, plus outputs and rr_ptr are zeroed.
- Equal-count case (NUM_WB_PORTS == NUM_EXEC_UNITS):
  - Every candidate is granted.
  - hold_valid never sets and exec_ready stays 1.
- Ordering: results from the same unit are written in presentation order (single holding entry guarantees this).

Optional Feature:
- Macro WB_RR_ARB_EN.
- Defined:
  - Scan starts at rr_ptr, wrapping modulo NUM_EXEC_UNITS.
  - After any cycle with at least one grant, rr_ptr ← (last granted unit + 1) mod NUM_EXEC_UNITS.
  - rr_ptr is unchanged when nothing is granted, and is reset to 0 by both rst and flush.
- Undefined: fixed priority with unit 0 highest, and no rr_ptr register.

Decomposition:
- Shared types package:
  - wb_result_t struct {preg, data, rob_idx}.
  - PREG_W and ROB_IDX_W constants, reused by the read-port arbiter and the ROB.
- Natural sub-module: wb_hold_reg, one instance per unit.
  - Contains the valid/payload register, the candidate mux and ready generation.
  - The top level contains the grant scan, port muxing and output registers.

Test Plan:
- Single result: unit1 valid, preg = 12, data = 0xDEADBEEF, rob = 3 → next cycle port0 prf_wr_en = 1, preg 12, data 0xDEADBEEF, cdb_rob_idx = 3; exec_ready stays 1.
- Contention (3 units, 2 ports):
  - Cycle 0: all three valid with pregs 5, 6, 7 → cycle 1: port0 = 5, port1 = 6, hold[2] set, exec_ready[2] = 0.
  - Cycle 1: units 0 and 1 present pregs 8 and 9 → cycle 2: port0 = 7, port1 = 8.
  - Cycle 2: hold[1] = 9 is pending → cycle 3: port0 = 9.
- x0 write: unit0 preg = 0, rob = 4 → port0 cdb_valid = 1, cdb_rob_idx = 4, prf_wr_en = 0.
- Flush while hold[2] is valid and unit0 presents a new result → next cycle all valids = 0 and exec_ready all 1; no write of either result ever appears.
- Reset asserted mid-contention → outputs zero next cycle and all exec_ready = 1.
- With WB_RR_ARB_EN, all three units valid every cycle for 6 cycles → grant pairs (0,1), (2,0), (1,2) repeating; no unit waits more than 1 cycle.
